// File: rtl/cache_refill_unit_if.sv
// Signal bundle between cache_refill_unit (slave) and the controller / data array / memory side (master).
// o_crit_valid exists only when CACHE_REFILL_CRITICAL_WORD_FIRST_EN is defined.
interface cache_refill_unit_if #(
   parameter int LINE_SIZE_BYTES = 64,
   parameter int DATA_WIDTH      = 32,
   parameter int WAYS            = 4,
   parameter int INDEX_WIDTH     = 8,
   parameter int TAG_BITS        = 18
);
   localparam int OFFSET_WIDTH  = $clog2(LINE_SIZE_BYTES);
   localparam int WORD_WIDTH    = OFFSET_WIDTH - 2;
   localparam int WAY_WIDTH     = $clog2(WAYS);
   localparam int ADDRESS_WIDTH = TAG_BITS + INDEX_WIDTH + OFFSET_WIDTH;

   logic                     i_miss_valid;
   logic                     o_miss_ready;
   logic [ADDRESS_WIDTH-1:0] i_miss_address;
   logic [WAY_WIDTH-1:0]     i_victim_way;
   logic                     i_victim_dirty;
   logic [TAG_BITS-1:0]      i_victim_tag;
   logic                     o_wb_rd_en;
   logic [DATA_WIDTH-1:0]    i_wb_data;
   logic                     o_mem_req;
   logic                     o_mem_we;
   logic [ADDRESS_WIDTH-1:0] o_mem_addr;
   logic [DATA_WIDTH-1:0]    o_mem_wdata;
   logic                     i_mem_ack;
   logic [DATA_WIDTH-1:0]    i_mem_rdata;
   logic                     o_fill_we;
   logic [WAY_WIDTH-1:0]     o_fill_way;
   logic [INDEX_WIDTH-1:0]   o_fill_index;
   logic [WORD_WIDTH-1:0]    o_fill_word;
   logic [DATA_WIDTH-1:0]    o_fill_data;
   logic                     o_tag_we;
   logic [TAG_BITS-1:0]      o_tag;
   logic                     o_done;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
   logic                     o_crit_valid;
`endif

   modport master (
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      input  o_crit_valid,
`endif
      output i_miss_valid, i_miss_address, i_victim_way, i_victim_dirty, i_victim_tag,
      output i_wb_data, i_mem_ack, i_mem_rdata,
      input  o_miss_ready, o_wb_rd_en, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
      input  o_fill_we, o_fill_way, o_fill_index, o_fill_word, o_fill_data,
      input  o_tag_we, o_tag, o_done
   );

   modport slave (
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      output o_crit_valid,
`endif
      input  i_miss_valid, i_miss_address, i_victim_way, i_victim_dirty, i_victim_tag,
      input  i_wb_data, i_mem_ack, i_mem_rdata,
      output o_miss_ready, o_wb_rd_en, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
      output o_fill_we, o_fill_way, o_fill_index, o_fill_word, o_fill_data,
      output o_tag_we, o_tag, o_done
   );
endinterface

// File: rtl/cache_refill_unit.sv
// Cache miss handler: optional dirty-victim writeback, line fill from memory, tag install, done pulse.
// Define CACHE_REFILL_CRITICAL_WORD_FIRST_EN to start the fill at the requested word and add o_crit_valid.
module cache_refill_unit #(
   parameter int LINE_SIZE_BYTES = 64,
   parameter int DATA_WIDTH      = 32,
   parameter int WAYS            = 4,
   parameter int INDEX_WIDTH     = 8,
   parameter int TAG_BITS        = 18
) (
   input logic                clk,
   input logic                rst,
   cache_refill_unit_if.slave bus
);
   localparam int WPL          = LINE_SIZE_BYTES / 4;
   localparam int OFFSET_WIDTH = $clog2(LINE_SIZE_BYTES);
   localparam int WORD_WIDTH   = OFFSET_WIDTH - 2;
   localparam int WAY_WIDTH    = $clog2(WAYS);

   typedef enum logic [2:0] {IDLE, WB_RD, WB_LAT, WB_WR, FILL, UPDATE} state_t;

   state_t                 state;
   state_t                 next_state;

   logic [TAG_BITS-1:0]    tag_q;
   logic [TAG_BITS-1:0]    victim_tag_q;
   logic [INDEX_WIDTH-1:0] index_q;
   logic [WAY_WIDTH-1:0]   way_q;
   logic [WORD_WIDTH-1:0]  word_cnt;
   logic [WORD_WIDTH-1:0]  beat_cnt;
   logic [WORD_WIDTH-1:0]  fill_word_q;
   logic [DATA_WIDTH-1:0]  wdata_q;
   logic [DATA_WIDTH-1:0]  fill_data_q;
   logic                   fill_pending;

   logic                   accept;
   logic                   mem_req;
   logic                   mem_ack;
   logic                   last_word;
   logic                   last_beat;
   logic [WORD_WIDTH-1:0]  accept_word;
   logic [WORD_WIDTH-1:0]  fill_start;

   // Every event is qualified by !rst so a reset cycle neither accepts a miss nor consumes an ack.
   assign accept    = !rst && (state == IDLE) && bus.i_miss_valid;
   assign mem_req   = !rst && ((state == WB_WR) || (state == FILL));
   assign mem_ack   = mem_req && bus.i_mem_ack;
   assign last_word = (word_cnt == WORD_WIDTH'(WPL - 1));
   assign last_beat = (beat_cnt == WORD_WIDTH'(WPL - 1));

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
   logic [WORD_WIDTH-1:0] crit_word_q;
   logic                  unused_addr_bits;

   assign accept_word      = bus.i_miss_address[OFFSET_WIDTH-1:2];
   assign fill_start       = crit_word_q;
   assign unused_addr_bits = ^bus.i_miss_address[1:0];
`else
   logic                  unused_addr_bits;

   assign accept_word      = '0;
   assign fill_start       = '0;
   assign unused_addr_bits = ^bus.i_miss_address[OFFSET_WIDTH-1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Writeback runs words 0..WPL-1 with three states per word; the fill counts WPL acks
   // separately from the word address because the address may start mid-line and wrap.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = bus.i_victim_dirty ? WB_RD : FILL;
         WB_RD:   next_state = WB_LAT;
         WB_LAT:  next_state = WB_WR;
         WB_WR:   if (mem_ack) next_state = last_word ? FILL : WB_RD;
         FILL:    if (mem_ack && last_beat) next_state = UPDATE;
         UPDATE:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q        <= '0;
         victim_tag_q <= '0;
         index_q      <= '0;
         way_q        <= '0;
         word_cnt     <= '0;
         beat_cnt     <= '0;
         fill_word_q  <= '0;
         wdata_q      <= '0;
         fill_data_q  <= '0;
         fill_pending <= 1'b0;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
         crit_word_q  <= '0;
`endif
      end else begin
         fill_pending <= 1'b0;
         if (accept) begin
            tag_q        <= bus.i_miss_address[OFFSET_WIDTH+INDEX_WIDTH +: TAG_BITS];
            index_q      <= bus.i_miss_address[OFFSET_WIDTH +: INDEX_WIDTH];
            way_q        <= bus.i_victim_way;
            victim_tag_q <= bus.i_victim_tag;
            word_cnt     <= bus.i_victim_dirty ? '0 : accept_word;
            beat_cnt     <= '0;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
            crit_word_q  <= accept_word;
`endif
         end
         if (state == WB_LAT) begin
            wdata_q <= bus.i_wb_data;
         end
         if ((state == WB_WR) && mem_ack) begin
            word_cnt <= last_word ? fill_start : word_cnt + WORD_WIDTH'(1);
         end
         if ((state == FILL) && mem_ack) begin
            fill_pending <= 1'b1;
            fill_data_q  <= bus.i_mem_rdata;
            fill_word_q  <= word_cnt;
            word_cnt     <= word_cnt + WORD_WIDTH'(1);
            beat_cnt     <= beat_cnt + WORD_WIDTH'(1);
         end
      end
   end

   // Outputs are forced to zero while rst is high, which also drops a request in flight.
   always_comb begin
      bus.o_miss_ready = 1'b0;
      bus.o_wb_rd_en   = 1'b0;
      bus.o_mem_req    = 1'b0;
      bus.o_mem_we     = 1'b0;
      bus.o_mem_addr   = '0;
      bus.o_mem_wdata  = '0;
      bus.o_fill_we    = 1'b0;
      bus.o_fill_way   = '0;
      bus.o_fill_index = '0;
      bus.o_fill_word  = '0;
      bus.o_fill_data  = '0;
      bus.o_tag_we     = 1'b0;
      bus.o_tag        = '0;
      bus.o_done       = 1'b0;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      bus.o_crit_valid = 1'b0;
`endif
      if (!rst) begin
         bus.o_miss_ready = (state == IDLE);
         bus.o_wb_rd_en   = (state == WB_RD);
         bus.o_mem_req    = mem_req;
         if (state == WB_WR) begin
            bus.o_mem_we    = 1'b1;
            bus.o_mem_addr  = {victim_tag_q, index_q, word_cnt, 2'b00};
            bus.o_mem_wdata = wdata_q;
         end else if (state == FILL) begin
            bus.o_mem_addr  = {tag_q, index_q, word_cnt, 2'b00};
         end
         bus.o_fill_we    = fill_pending;
         bus.o_fill_way   = way_q;
         bus.o_fill_index = index_q;
         bus.o_fill_word  = fill_pending ? fill_word_q : word_cnt;
         bus.o_fill_data  = fill_pending ? fill_data_q : '0;
         bus.o_tag_we     = (state == UPDATE);
         bus.o_tag        = tag_q;
         bus.o_done       = (state == UPDATE);
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
         bus.o_crit_valid = fill_pending && (fill_word_q == crit_word_q);
`endif
      end
   end
endmodule

// File: tb/tb_cache_refill_unit.sv
// Scoreboard bench for cache_refill_unit: a memory/data-array model answers the DUT and a
// monitor collects beats, fills and tag writes that each scenario task compares against its expectations.
module tb_cache_refill_unit;
   localparam int WPL = 16;

   typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} beat_t;
   typedef struct packed {logic [1:0] way; logic [7:0] index; logic [3:0] word; logic [31:0] data; logic crit;} fill_t;
   typedef struct packed {logic [1:0] way; logic [7:0] index; logic [17:0] tag;} tagw_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_refill_unit_if bus ();
   cache_refill_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
   wire crit_o = bus.o_crit_valid;
`else
   wire crit_o = 1'b0;
`endif
   wire [135:0] all_outs = {crit_o, bus.o_miss_ready, bus.o_wb_rd_en, bus.o_mem_req, bus.o_mem_we,
                            bus.o_mem_addr, bus.o_mem_wdata, bus.o_fill_we, bus.o_fill_way,
                            bus.o_fill_index, bus.o_fill_word, bus.o_fill_data, bus.o_tag_we,
                            bus.o_tag, bus.o_done};

   beat_t exp_beats[$], obs_beats[$];
   fill_t exp_fills[$], obs_fills[$];
   tagw_t exp_tags[$], obs_tags[$];

   int vectors = 0;
   int miscompares = 0;

   int  cyc = 0, wait_cnt = 0, ack_period = 1;
   bit  stray_acks = 1'b0;
   int  unstable_cnt = 0, fill_cnt = 0, done_cnt = 0, tag_cnt = 0, ack_total = 0, rd_cnt = 0;
   int  acc_cyc = 0, done_cyc = 0;
   logic        prev_waiting = 1'b0;
   logic [64:0] prev_req = '0;
   logic        rd_seen = 1'b0;
   logic [1:0]  rd_way = '0;
   logic [7:0]  rd_idx = '0;
   logic [3:0]  rd_word = '0;

   function automatic logic [31:0] mem_pattern(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] arr_pattern(input logic [1:0] way, input logic [7:0] idx, input logic [3:0] w);
      return {6'h28, way, idx, 4'hC, w, 8'h5C};
   endfunction

   // Memory responder and output monitor; all DUT outputs are sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (bus.i_miss_valid && bus.o_miss_ready) acc_cyc = cyc;
      if (bus.o_mem_req) begin
         if (prev_waiting && ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata} !== prev_req)) unstable_cnt++;
         if (wait_cnt >= ack_period - 1) begin
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = mem_pattern(bus.o_mem_addr);
            wait_cnt = 0;
            ack_total++;
            obs_beats.push_back('{bus.o_mem_we, bus.o_mem_addr, bus.o_mem_we ? bus.o_mem_wdata : 32'h0});
         end else begin
            bus.i_mem_ack   = 1'b0;
            bus.i_mem_rdata = 32'hBAD0_BAD0;
            wait_cnt++;
         end
         prev_waiting = !bus.i_mem_ack;
         prev_req     = {bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata};
      end else begin
         bus.i_mem_ack   = stray_acks;
         bus.i_mem_rdata = 32'hBAD1_BAD1;
         wait_cnt     = 0;
         prev_waiting = 1'b0;
      end
      if (bus.o_fill_we) begin
         obs_fills.push_back('{bus.o_fill_way, bus.o_fill_index, bus.o_fill_word, bus.o_fill_data, crit_o});
         fill_cnt++;
      end
      if (bus.o_tag_we) begin
         obs_tags.push_back('{bus.o_fill_way, bus.o_fill_index, bus.o_tag});
         tag_cnt++;
      end
      if (bus.o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      rd_seen = bus.o_wb_rd_en;
      rd_way  = bus.o_fill_way;
      rd_idx  = bus.o_fill_index;
      rd_word = bus.o_fill_word;
      if (rd_seen) rd_cnt++;
   end

   // Data-array read data appears only in the cycle after the read strobe.
   always @(posedge clk) begin
      #1;
      bus.i_wb_data = rd_seen ? arr_pattern(rd_way, rd_idx, rd_word) : 32'hDEAD_BEEF;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic flush_queues();
      exp_beats.delete(); obs_beats.delete();
      exp_fills.delete(); obs_fills.delete();
      exp_tags.delete();  obs_tags.delete();
   endtask

   // Pushes the expected memory beats, fills and tag write, then performs the handshake.
   task automatic issue_miss(input logic [31:0] addr, input logic [1:0] way, input logic dirty, input logic [17:0] vtag);
      logic [7:0]  idx;
      logic [17:0] tag;
      logic [3:0]  start, ww;
      logic [31:0] a;
      bit          accepted;
      idx = addr[13:6];
      tag = addr[31:14];
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      start = addr[5:2];
`else
      start = 4'd0;
`endif
      if (dirty) begin
         for (int w = 0; w < WPL; w++) begin
            ww = 4'(w);
            exp_beats.push_back('{1'b1, {vtag, idx, ww, 2'b00}, arr_pattern(way, idx, ww)});
         end
      end
      for (int k = 0; k < WPL; k++) begin
         ww = start + 4'(k);
         a  = {tag, idx, ww, 2'b00};
         exp_beats.push_back('{1'b0, a, 32'h0});
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
         exp_fills.push_back('{way, idx, ww, mem_pattern(a), (k == 0)});
`else
         exp_fills.push_back('{way, idx, ww, mem_pattern(a), 1'b0});
`endif
      end
      exp_tags.push_back('{way, idx, tag});

      @(posedge clk); #1;
      bus.i_miss_valid   = 1'b1;
      bus.i_miss_address = addr;
      bus.i_victim_way   = way;
      bus.i_victim_dirty = dirty;
      bus.i_victim_tag   = vtag;
      accepted = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.o_miss_ready === 1'b1) begin accepted = 1'b1; break; end
      end
      @(posedge clk); #1;
      bus.i_miss_valid   = 1'b0;
      bus.i_miss_address = $urandom;
      bus.i_victim_way   = ~way;
      bus.i_victim_dirty = ~dirty;
      bus.i_victim_tag   = 18'($urandom);
      vectors++;
      if (!accepted) begin
         miscompares++;
         $display("[TB] FAIL accept: o_miss_ready got %b, expected 1 within 20 cycles", bus.o_miss_ready);
      end
   endtask

   task automatic wait_done(input int budget, output bit timed_out);
      int base;
      base = done_cnt;
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_cnt != base) begin timed_out = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if (all_outs !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs cycle %0d: got %h, expected 0", i, all_outs);
         end
         if (i == 0) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.o_miss_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_ready: got %b, expected 1", bus.o_miss_ready);
      end
   endtask

   task automatic test_clean_miss();
      bit to;
      beat_t eb, ob;
      fill_t ef, of;
      tagw_t et, ot;
      flush_queues();
      ack_period = 1;
      issue_miss(32'h0001_2344, 2'd2, 1'b0, 18'h0);
      wait_done(100, to);
      vectors++;
      if (to || (done_cyc - acc_cyc != WPL + 1)) begin
         miscompares++;
         $display("[TB] FAIL clean_latency: got %0d cycles (timeout=%0b), expected %0d", done_cyc - acc_cyc, to, WPL + 1);
      end
      @(negedge clk);
      vectors++;
      if (bus.o_miss_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL clean_ready_after_done: got %b, expected 1", bus.o_miss_ready);
      end
      while (exp_beats.size() != 0) begin
         eb = exp_beats.pop_front();
         ob = (obs_beats.size() != 0) ? obs_beats.pop_front() : '0;
         vectors++;
         if (ob !== eb) begin
            miscompares++;
            $display("[TB] FAIL clean_beat: got we=%b addr=%h, expected we=%b addr=%h", ob.we, ob.addr, eb.we, eb.addr);
         end
      end
      while (exp_fills.size() != 0) begin
         ef = exp_fills.pop_front();
         of = (obs_fills.size() != 0) ? obs_fills.pop_front() : '0;
         vectors++;
         if (of !== ef) begin
            miscompares++;
            $display("[TB] FAIL clean_fill: got way=%0d idx=%h word=%0d data=%h, expected way=%0d idx=%h word=%0d data=%h",
                     of.way, of.index, of.word, of.data, ef.way, ef.index, ef.word, ef.data);
         end
      end
      et = exp_tags.pop_front();
      ot = (obs_tags.size() != 0) ? obs_tags.pop_front() : '0;
      vectors++;
      if (ot !== et) begin
         miscompares++;
         $display("[TB] FAIL clean_tag: got %h, expected %h", ot, et);
      end
   endtask

   task automatic test_dirty_miss();
      bit to;
      int rd_base;
      beat_t eb, ob;
      flush_queues();
      ack_period = 1;
      stray_acks = 1'b1;
      rd_base = rd_cnt;
      issue_miss(32'h0008_6348, 2'd1, 1'b1, 18'h3FFFF);
      wait_done(200, to);
      stray_acks = 1'b0;
      vectors++;
      if (to || (done_cyc - acc_cyc != 4 * WPL + 1)) begin
         miscompares++;
         $display("[TB] FAIL dirty_latency: got %0d cycles (timeout=%0b), expected %0d", done_cyc - acc_cyc, to, 4 * WPL + 1);
      end
      vectors++;
      if (rd_cnt - rd_base != WPL) begin
         miscompares++;
         $display("[TB] FAIL dirty_reads: got %0d strobes, expected %0d", rd_cnt - rd_base, WPL);
      end
      while (exp_beats.size() != 0) begin
         eb = exp_beats.pop_front();
         ob = (obs_beats.size() != 0) ? obs_beats.pop_front() : '0;
         vectors++;
         if (ob !== eb) begin
            miscompares++;
            $display("[TB] FAIL dirty_beat: got we=%b addr=%h data=%h, expected we=%b addr=%h data=%h",
                     ob.we, ob.addr, ob.data, eb.we, eb.addr, eb.data);
         end
      end
      vectors++;
      if ((obs_tags.size() == 0) || (obs_tags[0] !== exp_tags[0])) begin
         miscompares++;
         $display("[TB] FAIL dirty_tag: got %0d entries, expected %h", obs_tags.size(), exp_tags[0]);
      end
   endtask

   task automatic test_mem_stalls();
      bit to;
      int done_base, fill_base;
      logic [15:0] mask;
      fill_t ef, of;
      flush_queues();
      ack_period   = 4;
      unstable_cnt = 0;
      done_base    = done_cnt;
      fill_base    = fill_cnt;
      mask         = '0;
      issue_miss(32'h0F0F_0F28, 2'd3, 1'b1, 18'h12345);
      wait_done(600, to);
      repeat (5) @(posedge clk);
      ack_period = 1;
      vectors++;
      if (to || (done_cnt - done_base != 1)) begin
         miscompares++;
         $display("[TB] FAIL stall_done: got %0d pulses (timeout=%0b), expected 1", done_cnt - done_base, to);
      end
      vectors++;
      if (unstable_cnt != 0) begin
         miscompares++;
         $display("[TB] FAIL stall_hold: got %0d changes while waiting, expected 0", unstable_cnt);
      end
      vectors++;
      if (fill_cnt - fill_base != WPL) begin
         miscompares++;
         $display("[TB] FAIL stall_fill_count: got %0d, expected %0d", fill_cnt - fill_base, WPL);
      end
      while (exp_fills.size() != 0) begin
         ef = exp_fills.pop_front();
         of = (obs_fills.size() != 0) ? obs_fills.pop_front() : '0;
         mask[of.word] = 1'b1;
         vectors++;
         if (of !== ef) begin
            miscompares++;
            $display("[TB] FAIL stall_fill: got word=%0d data=%h, expected word=%0d data=%h", of.word, of.data, ef.word, ef.data);
         end
      end
      vectors++;
      if (mask !== 16'hFFFF) begin
         miscompares++;
         $display("[TB] FAIL stall_unique_words: got mask %h, expected ffff", mask);
      end
   endtask

   task automatic test_reset_mid_fill();
      bit to;
      bit reached;
      int ack_base, done_base, tag_base, fill_base;
      tagw_t et, ot;
      flush_queues();
      ack_period = 1;
      ack_base = ack_total;
      issue_miss(32'h0000_4000, 2'd0, 1'b0, 18'h0);
      reached = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         if (ack_total - ack_base >= 5) begin reached = 1'b1; break; end
      end
      #1;
      rst       = 1'b1;
      done_base = done_cnt;
      tag_base  = tag_cnt;
      fill_base = fill_cnt;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (30) @(negedge clk);
      vectors++;
      if (!reached) begin
         miscompares++;
         $display("[TB] FAIL midfill_acks: got %0d acks, expected 5", ack_total - ack_base);
      end
      vectors++;
      if ((done_cnt != done_base) || (tag_cnt != tag_base) || (fill_cnt != fill_base)) begin
         miscompares++;
         $display("[TB] FAIL midfill_quiet: got done+%0d tag+%0d fill+%0d, expected 0 0 0",
                  done_cnt - done_base, tag_cnt - tag_base, fill_cnt - fill_base);
      end
      vectors++;
      if ({bus.o_miss_ready, bus.o_mem_req} !== 2'b10) begin
         miscompares++;
         $display("[TB] FAIL midfill_idle: got ready=%b req=%b, expected ready=1 req=0", bus.o_miss_ready, bus.o_mem_req);
      end
      flush_queues();
      issue_miss(32'hABCD_0010, 2'd3, 1'b0, 18'h0);
      wait_done(100, to);
      vectors++;
      if (to || (obs_fills.size() != WPL)) begin
         miscompares++;
         $display("[TB] FAIL midfill_recover: got %0d fills (timeout=%0b), expected %0d", obs_fills.size(), to, WPL);
      end
      et = exp_tags.pop_front();
      ot = (obs_tags.size() != 0) ? obs_tags.pop_front() : '0;
      vectors++;
      if (ot !== et) begin
         miscompares++;
         $display("[TB] FAIL midfill_recover_tag: got %h, expected %h", ot, et);
      end
   endtask

   task automatic test_crit_word();
      bit to;
      int crit_seen;
      fill_t ef, of;
      flush_queues();
      ack_period = 1;
      crit_seen  = 0;
      issue_miss(32'h1234_5674, 2'd0, 1'b0, 18'h0);
      wait_done(100, to);
      vectors++;
      if (to) begin
         miscompares++;
         $display("[TB] FAIL crit_done: got timeout, expected done");
      end
      while (exp_fills.size() != 0) begin
         ef = exp_fills.pop_front();
         of = (obs_fills.size() != 0) ? obs_fills.pop_front() : '0;
         if (of.crit) crit_seen++;
         vectors++;
         if (of !== ef) begin
            miscompares++;
            $display("[TB] FAIL crit_fill_order: got word=%0d crit=%b, expected word=%0d crit=%b", of.word, of.crit, ef.word, ef.crit);
         end
      end
      vectors++;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      if (crit_seen != 1) begin
         miscompares++;
         $display("[TB] FAIL crit_pulses: got %0d, expected 1", crit_seen);
      end
`else
      if (crit_seen != 0) begin
         miscompares++;
         $display("[TB] FAIL crit_pulses: got %0d, expected 0", crit_seen);
      end
`endif
   endtask

   initial begin
      bus.i_miss_valid   = 1'b0;
      bus.i_miss_address = '0;
      bus.i_victim_way   = '0;
      bus.i_victim_dirty = 1'b0;
      bus.i_victim_tag   = '0;
      test_reset();
      test_clean_miss();
      test_dirty_miss();
      test_mem_stalls();
      test_reset_mid_fill();
      test_crit_word();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
